// File: rtl/prime_pkg.sv
// Shared types and constants for the sequential 6k+/-1 prime tester.
package prime_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned FIRST_CAND    = 5;
   localparam int unsigned CAND_STEP     = 6;

   typedef enum logic [1:0] {
      StIdle,
      StScreen,
      StLoop,
      StDone
   } state_e;

endpackage

// File: rtl/prime_trial_step.sv
// One trial-division step: tests candidate pair (i, i+2) against num.
module prime_trial_step
   import prime_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] num,
   input  logic [WIDTH-1:0] i,
   output logic             sq_gt,
   output logic             div_i,
   output logic             div_i2
);

   logic [2*WIDTH-1:0] i_wide;
   logic [2*WIDTH-1:0] num_wide;
   logic [2*WIDTH-1:0] i_sq;
   logic [WIDTH:0]     num_ext;
   logic [WIDTH:0]     i2;
   logic [WIDTH-1:0]   rem_i;
   logic [WIDTH:0]     rem_i2;

   // Square at double width so it never wraps; i+2 gets one carry bit.
   assign i_wide   = {{WIDTH{1'b0}}, i};
   assign num_wide = {{WIDTH{1'b0}}, num};
   assign i_sq     = i_wide * i_wide;
   assign num_ext  = {1'b0, num};
   assign i2       = {1'b0, i} + (WIDTH+1)'(2);

   // Divide-by-zero guard; i is only zero outside the loop state.
   assign rem_i  = (i == '0) ? num : (num % i);
   assign rem_i2 = (i2 == '0) ? num_ext : (num_ext % i2);

   assign sq_gt  = i_sq > num_wide;
   assign div_i  = (rem_i == '0);
   assign div_i2 = (rem_i2 == '0);

endmodule

// File: rtl/prime_seq_ctrl.sv
// Handshaked prime tester: screens small/2/3 cases, then walks 6k+/-1 candidates one pair per clock.
module prime_seq_ctrl
   import prime_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_num,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_num,
   output logic             out_is_prime,
   output logic [WIDTH-1:0] out_factor
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] num_q, num_d;
   logic [WIDTH-1:0] i_q, i_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_num_q, out_num_d;
   logic             out_is_prime_q, out_is_prime_d;
   logic [WIDTH-1:0] out_factor_q, out_factor_d;

   logic             sq_gt, div_i, div_i2;
   logic             done;
   logic             res_prime;
   logic [WIDTH-1:0] res_factor;

   prime_trial_step #(
      .WIDTH (WIDTH)
   ) u_trial_step (
      .num    (num_q),
      .i      (i_q),
      .sq_gt  (sq_gt),
      .div_i  (div_i),
      .div_i2 (div_i2)
   );

   always_comb begin
      state_d        = state_q;
      num_d          = num_q;
      i_d            = i_q;
      out_valid_d    = out_valid_q;
      out_num_d      = out_num_q;
      out_is_prime_d = out_is_prime_q;
      out_factor_d   = out_factor_q;
      done           = 1'b0;
      res_prime      = 1'b0;
      res_factor     = '0;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               num_d   = in_num;
               state_d = StScreen;
            end
         end
         StScreen: begin
            done = 1'b1;
            if (num_q <= WIDTH'(1)) begin
               res_prime = 1'b0;
            end else if (num_q <= WIDTH'(3)) begin
               res_prime = 1'b1;
            end else if (!num_q[0]) begin
               res_factor = WIDTH'(2);
            end else if ((num_q % WIDTH'(3)) == '0) begin
               res_factor = WIDTH'(3);
            end else begin
               done    = 1'b0;
               i_d     = WIDTH'(FIRST_CAND);
               state_d = StLoop;
            end
         end
         StLoop: begin
            done = 1'b1;
            if (sq_gt) begin
               res_prime = 1'b1;
            end else if (div_i) begin
               res_factor = i_q;
            end else if (div_i2) begin
               res_factor = i_q + WIDTH'(2);
            end else begin
               done = 1'b0;
               i_d  = i_q + WIDTH'(CAND_STEP);
            end
         end
         StDone: begin
            // No bypass: IDLE is entered first, so in_ready rises a cycle later.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (done) begin
         state_d        = StDone;
         out_valid_d    = 1'b1;
         out_num_d      = num_q;
         out_is_prime_d = res_prime;
         out_factor_d   = res_factor;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         num_q          <= '0;
         i_q            <= '0;
         out_valid_q    <= 1'b0;
         out_num_q      <= '0;
         out_is_prime_q <= 1'b0;
         out_factor_q   <= '0;
      end else begin
         state_q        <= state_d;
         num_q          <= num_d;
         i_q            <= i_d;
         out_valid_q    <= out_valid_d;
         out_num_q      <= out_num_d;
         out_is_prime_q <= out_is_prime_d;
         out_factor_q   <= out_factor_d;
      end
   end

   assign in_ready     = (state_q == StIdle);
   assign out_valid    = out_valid_q;
   assign out_num      = out_num_q;
   assign out_is_prime = out_is_prime_q;
   assign out_factor   = out_factor_q;

endmodule

// File: doc/prime_seq_ctrl.md
Name: prime_seq_ctrl

Overview:
- Multi-cycle, handshaked prime tester. Same 6k±1 trial-division algorithm as the team's combinational prime checker, but it tests one candidate pair (i, i+2) per clock instead of unrolling the whole loop.
- Sequences a shared trial-step datapath and reports primality plus the smallest factor found.
- Sits between a request producer (valid/ready) and a result consumer (valid/ready).

Parameters:
- WIDTH, 32, bit width of the number under test (even, ≥ 8).

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_num  in  WIDTH  number to test
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_num  out  WIDTH  echo of the tested number
- out_is_prime  out  1  1 = prime
- out_factor  out  WIDTH  smallest factor found; 0 if prime or num ≤ 1

Behaviour:
- Reset/clock: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE; out_valid, out_is_prime, out_num, out_factor, and internal num/i registers all 0.
- in_ready: equals (state == IDLE), driven combinationally from state.
- Accept: in_valid && in_ready at edge T latches in_num and moves to SCREEN.
- SCREEN (cycle T+1), first matching rule wins:
  - num ≤ 1: composite, factor 0.
  - num ≤ 3: prime, factor 0.
  - num % 2 == 0: composite, factor 2.
  - num % 3 == 0: composite, factor 3.
  - Resolved: go to DONE, out_valid = 1 at T+2.
  - Otherwise: i ← 5, go to LOOP.
- LOOP, one cycle per step, priority order:
  - i·i > num: prime.
  - num % i == 0: composite, factor i.
  - num % (i+2) == 0: composite, factor i+2.
  - else i ← i+6, stay in LOOP.
- LOOP widths:
  - i is a WIDTH-bit register.
  - i·i is computed at 2·WIDTH bits, so it never wraps.
  - i+2 is computed at WIDTH+1 bits.
- Latency: a result reached on the k-th LOOP cycle (k ≥ 1) gives out_valid at T+2+k.
- Worst case at WIDTH = 32 is num = 4294967291: 10923 LOOP cycles.
- DONE:
  - out_valid held high; out_* held stable until out_valid && out_ready.
  - Then returns to IDLE; in_ready rises the following cycle.
  - No bypass: a request cannot be accepted in the cycle a result is consumed.
- out_* registers are updated only on entry to DONE; outside DONE they keep their last values.
- Reset mid-operation (any state): abort, discard the request, outputs go to reset values next cycle.
- in_num changes while busy are ignored.
- out_ready while not out_valid has no effect.

Decomposition:
- Package prime_pkg holds:
  - state enum (IDLE, SCREEN, LOOP, DONE);
  - localparams FIRST_CAND = 5 and CAND_STEP = 6;
  - WIDTH default.
- One combinational sub-module, prime_trial_step:
  - inputs: num, i;
  - outputs: sq_gt (i·i > num), div_i (num % i == 0), div_i2 (num % (i+2) == 0).
- prime_seq_ctrl holds the FSM, the registers and the handshakes only.

Test Plan:
- in_num = 0, then 1, out_ready = 1 → out_valid at T+2, is_prime = 0, factor = 0. in_num = 2 and 3 → T+2, is_prime = 1, factor = 0.
- in_num = 4294967295 → T+2, is_prime = 0, factor = 3. in_num = 1000 → T+2, factor = 2.
- Loop paths:
  - in_num = 25 → T+3, composite, factor 5.
  - in_num = 49 → T+3, factor 7 (the i+2 path).
  - in_num = 121 → T+4, factor 11.
  - in_num = 5 → T+3, prime.
- in_num = 4294967291 → out_valid exactly at T+10925, is_prime = 1, factor = 0; in_ready low throughout.
- Backpressure: in_num = 25 with out_ready low for 5 cycles → out_* stable, in_ready = 0; after the out_ready pulse, in_ready = 1 the next cycle. A back-to-back second request is accepted then.
- Reset mid-operation: rst high for one cycle while in LOOP on 4294967291 → next cycle state IDLE, out_valid = 0, in_ready = 1, outputs all 0. A new request for 7 → prime at T+3.
